// File: rtl/mem_access.sv
// MEM pipeline stage: one req/ack data-memory access per instruction, load lane extraction and extension.
// Optional feature: define MEM_MISALIGN_CHECK_EN to suppress and flag misaligned accesses.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] inst_addr_i,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [63:0] raddr_i,
    input  logic [63:0] waddr_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wmask_i,
    input  logic [2:0]  mem_funct3_i,
    input  logic [63:0] rd_wdata_i,
    input  logic [4:0]  rd_waddr_i,
    input  logic        reg_wen_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    output logic [7:0]  dmem_wmask_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    output logic        mem_hold_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic [63:0] inst_addr_o,
    output logic [63:0] rd_wdata_o,
    output logic [4:0]  rd_waddr_o,
    output logic        reg_wen_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic        is_load_q, is_load_d;
    logic [63:0] rdata_q, rdata_d;
    logic [31:0] tmo_q, tmo_d;
    logic        bus_err_q, bus_err_d;

    logic        op_req;
    logic [63:0] req_addr;
    logic        misaligned;
    logic [63:0] lane;
    logic [63:0] load_ext;

    assign op_req   = ren_i | wen_i;
    assign req_addr = wen_i ? waddr_i : raddr_i;

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (mem_funct3_i[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    // Bytes shifted in from above bit 63 are zero, so overhanging loads read zeros.
    assign lane = rdata_q >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = lane;
        case (funct3_q[1:0])
            2'b00:   load_ext = {{56{~funct3_q[2] & lane[7]}},  lane[7:0]};
            2'b01:   load_ext = {{48{~funct3_q[2] & lane[15]}}, lane[15:0]};
            2'b10:   load_ext = {{32{~funct3_q[2] & lane[31]}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        is_load_d = is_load_q;
        rdata_d   = rdata_q;
        tmo_d     = tmo_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_req && !misaligned) begin
                    state_d   = BUSY;
                    addr_d    = req_addr;
                    wdata_d   = wdata_i;
                    wmask_d   = wmask_i;
                    funct3_d  = mem_funct3_i;
                    we_d      = wen_i;
                    is_load_d = ren_i & ~wen_i;
                    tmo_d     = '0;
                end
            end
            BUSY: begin
                if (dmem_ack_i) begin
                    state_d = DONE;
                    rdata_d = dmem_rdata_i;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q + 32'd1 == 32'(TIMEOUT_CYCLES))) begin
                    state_d   = DONE;
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_hold_o  = 1'b0;
        misalign_o  = 1'b0;
        reg_wen_o   = reg_wen_i;
        rd_wdata_o  = rd_wdata_i;
        case (state_q)
            IDLE: begin
                mem_hold_o = op_req & ~misaligned;
                misalign_o = op_req & misaligned;
                reg_wen_o  = reg_wen_i & ~op_req;
            end
            BUSY: begin
                mem_hold_o = 1'b1;
                reg_wen_o  = 1'b0;
            end
            DONE: begin
                if (is_load_q) begin
                    rd_wdata_o = load_ext;
                end
            end
            default: begin
                reg_wen_o = 1'b0;
            end
        endcase
    end

    assign inst_addr_o  = inst_addr_i;
    assign rd_waddr_o   = rd_waddr_i;
    assign dmem_req_o   = (state_q == BUSY);
    assign dmem_we_o    = (state_q == BUSY) & we_q;
    assign dmem_addr_o  = {addr_q[63:3], 3'b000};
    assign dmem_wdata_o = wdata_q;
    assign dmem_wmask_o = wmask_q;
    assign bus_err_o    = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            is_load_q <= 1'b0;
            rdata_q   <= '0;
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            is_load_q <= is_load_d;
            rdata_q   <= rdata_d;
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end
endmodule
